// File: rtl/num_format_conv_pipe.sv
// Two-stage valid/ready converter between U2, U1 and sign-magnitude signed words.
// Define NUM_CONV_SATURATE_EN to clamp overflowed results instead of wrapping them.
module num_format_conv_pipe #(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_data,
  input  logic [1:0]          i_mode,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [BITS-1:0]     o_data,
  output logic                o_overflow,
  output logic                o_valid,
  input  logic                i_ready,
  input  logic                i_clr_cnt,
  output logic [CNT_BITS-1:0] o_ovf_count
);

  typedef enum logic [1:0] {
    ModeU2ToU1 = 2'd0,
    ModeU1ToU2 = 2'd1,
    ModeU2ToSm = 2'd2,
    ModeSmToU2 = 2'd3
  } modeE;

  localparam logic [BITS-1:0]     MinVal = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0]     One    = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CntOne = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CntMax = '1;

  logic                s1Valid_q, s1Valid_d;
  logic [BITS-1:0]     s1Data_q, s1Data_d;
  modeE                s1Mode_q, s1Mode_d;
  logic                outValid_q, outValid_d;
  logic [BITS-1:0]     outData_q, outData_d;
  logic                outOvf_q, outOvf_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic            s2Load;
  logic            inXfer;
  logic            outXfer;
  logic [BITS-1:0] convData;
  logic            convOvf;
  logic [BITS-1:0] negX;
  logic [BITS-1:0] smMag;
  logic [BITS-1:0] smNeg;

  // Stage 2 can take a new beat when it is empty or its beat leaves this cycle.
  assign s2Load  = !outValid_q || i_ready;
  assign o_ready = !i_rst && (!s1Valid_q || s2Load);
  assign inXfer  = i_valid && o_ready;
  assign outXfer = outValid_q && i_ready;

  assign negX  = ~s1Data_q + One;
  assign smMag = {1'b0, s1Data_q[BITS-2:0]};
  assign smNeg = ~smMag + One;

  always_comb begin
    convData = s1Data_q;
    convOvf  = 1'b0;
    if (s1Data_q[BITS-1]) begin
      case (s1Mode_q)
        ModeU2ToU1: begin
          convData = s1Data_q - One;
          if (s1Data_q == MinVal) begin
            convOvf = 1'b1;
`ifdef NUM_CONV_SATURATE_EN
            convData = MinVal;
`endif
          end
        end
        ModeU1ToU2: convData = s1Data_q + One;
        ModeU2ToSm: begin
          convData = {1'b1, negX[BITS-2:0]};
          if (s1Data_q == MinVal) begin
            convOvf = 1'b1;
`ifdef NUM_CONV_SATURATE_EN
            convData = '1;
`endif
          end
        end
        ModeSmToU2: convData = smNeg;
        default:    convData = s1Data_q;
      endcase
    end
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Data_d   = s1Data_q;
    s1Mode_d   = s1Mode_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outOvf_d   = outOvf_q;
    cnt_d      = cnt_q;
    if (o_ready) s1Valid_d = i_valid;
    if (inXfer) begin
      s1Data_d = i_data;
      s1Mode_d = modeE'(i_mode);
    end
    if (s2Load) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outData_d = convData;
        outOvf_d  = convOvf;
      end
    end
    // Clear takes priority over a same-cycle overflow delivery.
    if (i_clr_cnt) cnt_d = '0;
    else if (outXfer && outOvf_q && cnt_q != CntMax) cnt_d = cnt_q + CntOne;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1Valid_q  <= 1'b0;
      s1Data_q   <= '0;
      s1Mode_q   <= ModeU2ToU1;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outOvf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Data_q   <= s1Data_d;
      s1Mode_q   <= s1Mode_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outOvf_q   <= outOvf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid     = outValid_q;
  assign o_data      = outData_q;
  assign o_overflow  = outOvf_q;
  assign o_ovf_count = cnt_q;

endmodule

// File: tb/tb_num_format_conv_pipe.sv
// Directed bench for num_format_conv_pipe at BITS=4, CNT_BITS=2.
// Expected overflow words follow NUM_CONV_SATURATE_EN when it is defined.
module tb_num_format_conv_pipe;

  localparam int BITS     = 4;
  localparam int CNT_BITS = 2;

`ifdef NUM_CONV_SATURATE_EN
  localparam logic [3:0] M0Ovf = 4'b1000;
  localparam logic [3:0] M2Ovf = 4'b1111;
`else
  localparam logic [3:0] M0Ovf = 4'b0111;
  localparam logic [3:0] M2Ovf = 4'b1000;
`endif

  logic                clk = 1'b0;
  logic                iRst;
  logic [BITS-1:0]     iData;
  logic [1:0]          iMode;
  logic                iValid;
  logic                oReady;
  logic [BITS-1:0]     oData;
  logic                oOverflow;
  logic                oValid;
  logic                iReady;
  logic                iClrCnt;
  logic [CNT_BITS-1:0] oOvfCount;

  int vectorCount = 0;
  int missCount   = 0;
  logic [4:0] gotQ[$];

  always #5 clk = ~clk;

  num_format_conv_pipe #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .i_clk      (clk),
    .i_rst      (iRst),
    .i_data     (iData),
    .i_mode     (iMode),
    .i_valid    (iValid),
    .o_ready    (oReady),
    .o_data     (oData),
    .o_overflow (oOverflow),
    .o_valid    (oValid),
    .i_ready    (iReady),
    .i_clr_cnt  (iClrCnt),
    .o_ovf_count(oOvfCount)
  );

  // Every delivered beat is logged as {overflow, data} for in-order checking.
  always @(negedge clk) begin
    if (!iRst && oValid && iReady) gotQ.push_back({oOverflow, oData});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] popBeat;
    if (gotQ.size() == 0) return 32'hDEAD;
    return {27'b0, gotQ.pop_front()};
  endfunction

  task automatic applyStimulus(input logic [3:0] d, input logic [1:0] m);
    logic accepted;
    iData  = d;
    iMode  = m;
    iValid = 1'b1;
    for (int guard = 0; guard < 50; guard++) begin
      @(negedge clk);
      accepted = oReady;
      tick();
      if (accepted) break;
    end
    if (!accepted) checkOutput("input accept", {31'b0, accepted}, 32'd1);
    iValid = 1'b0;
  endtask

  task automatic drain;
    iReady = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRst = 1'b1; iData = '0; iMode = '0; iValid = 1'b0; iReady = 1'b1; iClrCnt = 1'b0;
    repeat (2) tick();
    checkOutput("reset o_valid", {31'b0, oValid}, 32'd0);
    checkOutput("reset o_data", {28'b0, oData}, 32'd0);
    checkOutput("reset o_overflow", {31'b0, oOverflow}, 32'd0);
    checkOutput("reset count", {30'b0, oOvfCount}, 32'd0);
    checkOutput("reset o_ready", {31'b0, oReady}, 32'd0);
    iRst = 1'b0;
    #1;
    checkOutput("ready after reset", {31'b0, oReady}, 32'd1);

    // Latency: beat accepted at edge N shows on o_valid after edge N+1.
    iData = 4'b1101; iMode = 2'd0; iValid = 1'b1;
    tick();
    checkOutput("lat early valid", {31'b0, oValid}, 32'd0);
    iData = 4'b0101;
    tick();
    iValid = 1'b0;
    checkOutput("lat beat1 valid", {31'b0, oValid}, 32'd1);
    checkOutput("lat beat1 data", {28'b0, oData}, 32'b1100);
    checkOutput("lat beat1 ovf", {31'b0, oOverflow}, 32'd0);
    tick();
    checkOutput("lat beat2 valid", {31'b0, oValid}, 32'd1);
    checkOutput("lat beat2 data", {28'b0, oData}, 32'b0101);
    tick();
    checkOutput("lat idle valid", {31'b0, oValid}, 32'd0);
    gotQ.delete();

    applyStimulus(4'b1000, 2'd0);
    drain();
    checkOutput("m0 overflow beat", popBeat(), {27'b0, 1'b1, M0Ovf});
    checkOutput("m0 overflow count", {30'b0, oOvfCount}, 32'd1);

    applyStimulus(4'b1111, 2'd1);
    applyStimulus(4'b1101, 2'd2);
    applyStimulus(4'b1011, 2'd3);
    applyStimulus(4'b1000, 2'd3);
    applyStimulus(4'b1000, 2'd2);
    applyStimulus(4'b0011, 2'd2);
    drain();
    checkOutput("m1 neg zero", popBeat(), 32'b0_0000);
    checkOutput("m2 1101", popBeat(), 32'b0_1011);
    checkOutput("m3 1011", popBeat(), 32'b0_1101);
    checkOutput("m3 neg zero", popBeat(), 32'b0_0000);
    checkOutput("m2 overflow", popBeat(), {27'b0, 1'b1, M2Ovf});
    checkOutput("m2 positive", popBeat(), 32'b0_0011);
    checkOutput("modes count", {30'b0, oOvfCount}, 32'd2);

    // Backpressure: hold i_ready low until both stages are full.
    iReady = 1'b0;
    applyStimulus(4'b0001, 2'd0);
    applyStimulus(4'b1111, 2'd0);
    checkOutput("stall ready low", {31'b0, oReady}, 32'd0);
    checkOutput("stall valid", {31'b0, oValid}, 32'd1);
    checkOutput("stall data", {28'b0, oData}, 32'b0001);
    repeat (2) tick();
    checkOutput("stall held data", {28'b0, oData}, 32'b0001);
    checkOutput("stall held valid", {31'b0, oValid}, 32'd1);
    checkOutput("stall held ready", {31'b0, oReady}, 32'd0);
    iReady = 1'b1;
    applyStimulus(4'b0110, 2'd1);
    applyStimulus(4'b1001, 2'd1);
    drain();
    checkOutput("stall beat total", gotQ.size(), 32'd4);
    checkOutput("stall beat1", popBeat(), 32'b0_0001);
    checkOutput("stall beat2", popBeat(), 32'b0_1110);
    checkOutput("stall beat3", popBeat(), 32'b0_0110);
    checkOutput("stall beat4", popBeat(), 32'b0_1010);

    iClrCnt = 1'b1;
    tick();
    iClrCnt = 1'b0;
    checkOutput("clear count", {30'b0, oOvfCount}, 32'd0);
    repeat (5) applyStimulus(4'b1000, 2'd0);
    drain();
    checkOutput("saturated count", {30'b0, oOvfCount}, 32'd3);
    gotQ.delete();

    iReady = 1'b0;
    applyStimulus(4'b1000, 2'd0);
    for (int i = 0; i < 10 && !oValid; i++) tick();
    checkOutput("sixth ovf waiting", {31'b0, oValid}, 32'd1);
    iReady = 1'b1;
    iClrCnt = 1'b1;
    tick();
    iClrCnt = 1'b0;
    checkOutput("clear beats increment", {30'b0, oOvfCount}, 32'd0);
    checkOutput("sixth ovf delivered", {31'b0, oValid}, 32'd0);
    checkOutput("sixth ovf beat", popBeat(), {27'b0, 1'b1, M0Ovf});

    applyStimulus(4'b1000, 2'd0);
    drain();
    checkOutput("pre-reset count", {30'b0, oOvfCount}, 32'd1);
    gotQ.delete();
    iReady = 1'b0;
    applyStimulus(4'b0010, 2'd0);
    applyStimulus(4'b0011, 2'd0);
    checkOutput("in-flight valid", {31'b0, oValid}, 32'd1);
    iRst = 1'b1;
    #1;
    checkOutput("ready in reset", {31'b0, oReady}, 32'd0);
    tick();
    checkOutput("mid reset valid", {31'b0, oValid}, 32'd0);
    checkOutput("mid reset count", {30'b0, oOvfCount}, 32'd0);
    checkOutput("mid reset data", {28'b0, oData}, 32'd0);
    iRst = 1'b0;
    drain();
    checkOutput("dropped beats", gotQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
